multicycle_control_fsm: RTL

Control unit for the multicycle RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux select and write enable. It is also the producer of the 4-bit `ALUSel` code the ALU consumes, using the same encoding the ALU decodes. It sits between the instruction register and the shared datapath (PC, memory, register file, ALU).

---
 rtl/riscv_mc_pkg.sv | 56 +++++
 rtl/alu_sel_decoder.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 131 +++++++++++++
 3 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared constants for the multicycle RISC-V control path: states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_mc_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_sel_decoder.sv
// ALU operation decode from funct fields, with forced add/sub for address and
// compare cycles. MC_FULL_ALU_EN enables the shift/compare/xor funct3 codes.
module alu_sel_decoder
  import riscv_mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       force_add,
  input  logic       force_sub,
  output logic [3:0] alu_sel,
  output logic       illegal_funct
);

  logic is_r, is_alu, f3_unsupported;

  assign is_r   = (op == OP_R);
  assign is_alu = is_r | (op == OP_I);

`ifdef MC_FULL_ALU_EN
  assign f3_unsupported = 1'b0;
`else
  // Current ALU only implements add/sub/or/and.
  assign f3_unsupported = (funct3 >= 3'b001) && (funct3 <= 3'b101);
`endif

  assign illegal_funct = is_alu & f3_unsupported;

  always_comb begin
    alu_sel = {funct7b5 & (is_r | (funct3 == 3'b101)), funct3};
    if (force_sub)      alu_sel = ALU_SUB;
    else if (force_add) alu_sel = ALU_ADD;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: Moore FSM driving datapath selects/enables.
// Optional build macro MC_FULL_ALU_EN widens the set of legal ALU funct3 codes.
module multicycle_control_fsm
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUSel,
  output logic       Instr_Done,
  output logic       Illegal_Instr
);

  state_t     state_q, state_d;
  logic       pc_update, branch, force_add, force_sub, illegal_funct;
  logic [3:0] dec_sel;

  alu_sel_decoder u_dec (
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .force_add    (force_add),
    .force_sub    (force_sub),
    .alu_sel      (dec_sel),
    .illegal_funct(illegal_funct)
  );

  assign force_add = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_MEMADR) || (state_q == S_JAL);
  assign force_sub = (state_q == S_BEQ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = illegal_funct ? S_ILLEGAL : S_EXECUTER;
          OP_I:         state_d = illegal_funct ? S_ILLEGAL : S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_REG;
    ALUSel        = ALU_ADD;
    Instr_Done    = 1'b0;
    Illegal_Instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES;
        ALUSel = dec_sel; pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; ALUSel = dec_sel;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG; ALUSrcB = SRCB_IMM; ALUSel = dec_sel;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = RES_DATA; RegWrite = 1'b1; Instr_Done = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; Instr_Done = 1'b1; end
      S_EXECUTER: begin ALUSrcA = SRCA_REG; ALUSrcB = SRCB_REG; ALUSel = dec_sel; end
      S_EXECUTEI: begin ALUSrcA = SRCA_REG; ALUSrcB = SRCB_IMM; ALUSel = dec_sel; end
      S_ALUWB:    begin RegWrite = 1'b1; Instr_Done = 1'b1; end
      S_BEQ: begin
        ALUSrcA = SRCA_REG; ALUSel = dec_sel; branch = 1'b1; Instr_Done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; ALUSel = dec_sel; pc_update = 1'b1;
      end
      S_ILLEGAL:  Illegal_Instr = 1'b1;
      default: ;
    endcase
    // Reset abandons whatever instruction is in flight: nothing may write.
    if (rst) begin
      pc_update     = 1'b0;
      branch        = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_REG;
      ALUSel        = ALU_ADD;
      Instr_Done    = 1'b0;
      Illegal_Instr = 1'b0;
    end
  end

  assign ImmSrc  = rst ? IMM_I : imm_src_of(op);
  assign PCWrite = pc_update | (branch & Zero);

endmodule
